// File: rtl/fetch_resp_if.sv
// Fetch-side valid/ready read port between the fetch unit (master) and fetch_resp (slave).
interface fetch_resp_if;
    logic        axi_valid;
    logic [63:0] axi_addr;
    logic [1:0]  axi_size;
    logic        axi_ready;
    logic [63:0] axi_data_read;
    logic [1:0]  axi_resp;

    modport master (
        output axi_valid, axi_addr, axi_size,
        input  axi_ready, axi_data_read, axi_resp
    );

    modport slave (
        input  axi_valid, axi_addr, axi_size,
        output axi_ready, axi_data_read, axi_resp
    );
endinterface

// File: rtl/fetch_resp.sv
// Fetch responder: decodes/validates requests, serves from a one-line buffer or backing memory.
// Optional line buffer enabled by defining FETCH_RESP_LINEBUF_EN.
//
// state  | meaning
// S_IDLE | waiting for a request; range/alignment/hit decided in one cycle
// S_MEM  | o_mem_req held high until i_mem_ack
// S_RESP | o_axi_ready pulse, then back to S_IDLE
module fetch_resp #(
    parameter logic [63:0] ADDR_BASE  = 64'h8000_0000,
    parameter logic [63:0] ADDR_BYTES = 64'h0800_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    fetch_resp_if.slave axi,
    input  logic        i_flush,
    output logic        o_mem_req,
    output logic [63:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [63:0] i_mem_rdata,
    input  logic        i_mem_err
);

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    state_t      state_q, state_d;
    logic        ready_q, ready_d;
    logic [63:0] data_q, data_d;
    logic [1:0]  resp_q, resp_d;
    logic        req_q, req_d;
    logic [63:0] maddr_q, maddr_d;
    logic        fill;
    logic        hit;
    logic        in_range;
    logic        aligned;
    logic [64:0] range_end;
    logic [63:0] buf_data;

    function automatic logic [63:0] extract(input logic [63:0] line, input logic [2:0] off,
                                            input logic [1:0] sz);
        logic [63:0] s;
        s = line >> {off, 3'b000};
        case (sz)
            2'b00:   extract = {56'b0, s[7:0]};
            2'b01:   extract = {48'b0, s[15:0]};
            2'b10:   extract = {32'b0, s[31:0]};
            default: extract = s;
        endcase
    endfunction

    // 65-bit compare so a window ending at the top of the address space cannot wrap
    assign range_end = {1'b0, ADDR_BASE} + {1'b0, ADDR_BYTES};
    assign in_range  = ({1'b0, axi.axi_addr} >= {1'b0, ADDR_BASE}) &&
                       ({1'b0, axi.axi_addr} < range_end);

    always_comb begin
        case (axi.axi_size)
            2'b00:   aligned = 1'b1;
            2'b01:   aligned = (axi.axi_addr[0] == 1'b0);
            2'b10:   aligned = (axi.axi_addr[1:0] == 2'b00);
            default: aligned = (axi.axi_addr[2:0] == 3'b000);
        endcase
    end

`ifdef FETCH_RESP_LINEBUF_EN
    logic        buf_valid;
    logic [60:0] buf_tag;

    // flush has priority over a coincident fill
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else begin
            if (fill) begin
                buf_tag  <= axi.axi_addr[63:3];
                buf_data <= i_mem_rdata;
            end
            if (i_flush)   buf_valid <= 1'b0;
            else if (fill) buf_valid <= 1'b1;
        end
    end

    assign hit = buf_valid && (buf_tag == axi.axi_addr[63:3]);
`else
    logic unused_nobuf;
    assign unused_nobuf = i_flush ^ fill;
    assign buf_data     = '0;
    assign hit          = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            data_q  <= '0;
            resp_q  <= RESP_OKAY;
            req_q   <= 1'b0;
            maddr_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            data_q  <= data_d;
            resp_q  <= resp_d;
            req_q   <= req_d;
            maddr_q <= maddr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        data_d  = data_q;
        resp_d  = resp_q;
        req_d   = req_q;
        maddr_d = maddr_q;
        fill    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (axi.axi_valid) begin
                    if (!in_range) begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        data_d  = '0;
                        resp_d  = RESP_DECERR;
                    end else if (!aligned) begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        data_d  = '0;
                        resp_d  = RESP_SLVERR;
                    end else if (hit) begin
                        state_d = S_RESP;
                        ready_d = 1'b1;
                        data_d  = extract(buf_data, axi.axi_addr[2:0], axi.axi_size);
                        resp_d  = RESP_OKAY;
                    end else begin
                        state_d = S_MEM;
                        req_d   = 1'b1;
                        maddr_d = {axi.axi_addr[63:3], 3'b000};
                    end
                end
            end
            S_MEM: begin
                if (i_mem_ack) begin
                    state_d = S_RESP;
                    ready_d = 1'b1;
                    req_d   = 1'b0;
                    if (i_mem_err) begin
                        data_d = '0;
                        resp_d = RESP_SLVERR;
                    end else begin
                        data_d = extract(i_mem_rdata, axi.axi_addr[2:0], axi.axi_size);
                        resp_d = RESP_OKAY;
                        fill   = 1'b1;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign axi.axi_ready     = ready_q;
    assign axi.axi_data_read = data_q;
    assign axi.axi_resp      = resp_q;
    assign o_mem_req         = req_q;
    assign o_mem_addr        = maddr_q;

endmodule

// File: tb/tb_fetch_resp.sv
// Directed self-checking bench for fetch_resp; expectations follow the line-buffer build setting.
module tb_fetch_resp;

`ifdef FETCH_RESP_LINEBUF_EN
    localparam bit LB = 1'b1;
`else
    localparam bit LB = 1'b0;
`endif

    logic        i_clk;
    logic        i_rst;
    logic        i_flush;
    logic        o_mem_req;
    logic [63:0] o_mem_addr;
    logic        i_mem_ack;
    logic [63:0] i_mem_rdata;
    logic        i_mem_err;

    int tests;
    int fails;

    fetch_resp_if bus ();

    fetch_resp dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .axi         (bus.slave),
        .i_flush     (i_flush),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr),
        .i_mem_ack   (i_mem_ack),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_err   (i_mem_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request with exact-latency checks; memory acks after dly extra MEM cycles.
    task automatic req(input string tag, input logic [63:0] a, input logic [1:0] sz,
                       input bit exp_mem, input int dly, input logic [63:0] rd, input bit er,
                       input bit fl_ack, input logic [63:0] exp_d, input logic [1:0] exp_r);
        @(negedge i_clk);
        bus.axi_valid = 1'b1;
        bus.axi_addr  = a;
        bus.axi_size  = sz;
        @(posedge i_clk); #1;
        if (exp_mem) begin
            check({tag, ".mem_req"}, {63'b0, o_mem_req}, 64'd1);
            check({tag, ".mem_addr"}, o_mem_addr, {a[63:3], 3'b000});
            check({tag, ".no_early_ready"}, {63'b0, bus.axi_ready}, 64'd0);
            repeat (dly) @(posedge i_clk);
            @(negedge i_clk);
            i_mem_ack   = 1'b1;
            i_mem_rdata = rd;
            i_mem_err   = er;
            i_flush     = fl_ack;
            @(posedge i_clk); #1;
            i_mem_ack = 1'b0;
            i_mem_err = 1'b0;
            i_flush   = 1'b0;
            check({tag, ".req_drop"}, {63'b0, o_mem_req}, 64'd0);
        end else begin
            check({tag, ".no_mem_req"}, {63'b0, o_mem_req}, 64'd0);
        end
        check({tag, ".ready"}, {63'b0, bus.axi_ready}, 64'd1);
        check({tag, ".data"}, bus.axi_data_read, exp_d);
        check({tag, ".resp"}, {62'b0, bus.axi_resp}, {62'b0, exp_r});
        @(negedge i_clk);
        bus.axi_valid = 1'b0;
        @(posedge i_clk); #1;
        check({tag, ".ready_pulse"}, {63'b0, bus.axi_ready}, 64'd0);
        check({tag, ".data_hold"}, bus.axi_data_read, exp_d);
    endtask

    initial begin
        tests         = 0;
        fails         = 0;
        i_rst         = 1'b1;
        i_flush       = 1'b0;
        i_mem_ack     = 1'b0;
        i_mem_rdata   = '0;
        i_mem_err     = 1'b0;
        bus.axi_valid = 1'b0;
        bus.axi_addr  = '0;
        bus.axi_size  = 2'b00;

        repeat (2) @(negedge i_clk);
        check("rst.ready", {63'b0, bus.axi_ready}, 64'd0);
        check("rst.data", bus.axi_data_read, 64'd0);
        check("rst.resp", {62'b0, bus.axi_resp}, 64'd0);
        check("rst.mem_req", {63'b0, o_mem_req}, 64'd0);
        check("rst.mem_addr", o_mem_addr, 64'd0);
        i_rst = 1'b0;

        req("miss0", 64'h8000_0000, 2'b10, 1'b1, 1, 64'h1111_2222_3333_4444, 1'b0, 1'b0,
            64'h3333_4444, 2'b00);
        req("hit4", 64'h8000_0004, 2'b10, !LB, 0, 64'h1111_2222_3333_4444, 1'b0, 1'b0,
            64'h1111_2222, 2'b00);
        req("misal", 64'h8000_0002, 2'b10, 1'b0, 0, '0, 1'b0, 1'b0, 64'd0, 2'b10);
        req("below", 64'h7FFF_FFFC, 2'b10, 1'b0, 0, '0, 1'b0, 1'b0, 64'd0, 2'b11);

        @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        req("flush_err", 64'h8000_0004, 2'b10, 1'b1, 0, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b0,
            64'd0, 2'b10);
        req("after_err", 64'h8000_0004, 2'b10, 1'b1, 2, 64'h1111_2222_3333_4444, 1'b0, 1'b0,
            64'h1111_2222, 2'b00);

        req("flush_ack", 64'h8000_0008, 2'b11, 1'b1, 0, 64'h5555_6666_7777_8888, 1'b0, 1'b1,
            64'h5555_6666_7777_8888, 2'b00);
        req("after_flush_ack", 64'h8000_0008, 2'b11, 1'b1, 0, 64'h5555_6666_7777_8888, 1'b0,
            1'b0, 64'h5555_6666_7777_8888, 2'b00);

        @(negedge i_clk);
        bus.axi_valid = 1'b1;
        bus.axi_addr  = 64'h8000_0010;
        bus.axi_size  = 2'b11;
        @(posedge i_clk); #1;
        check("rst_mem.req_up", {63'b0, o_mem_req}, 64'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("rst_mem.req_drop", {63'b0, o_mem_req}, 64'd0);
        check("rst_mem.ready", {63'b0, bus.axi_ready}, 64'd0);
        check("rst_mem.mem_addr", o_mem_addr, 64'd0);
        @(negedge i_clk);
        bus.axi_valid = 1'b0;
        i_rst         = 1'b0;
        req("post_rst", 64'h8000_0008, 2'b11, 1'b1, 0, 64'h5555_6666_7777_8888, 1'b0, 1'b0,
            64'h5555_6666_7777_8888, 2'b00);

        req("above", 64'h8800_0000, 2'b00, 1'b0, 0, '0, 1'b0, 1'b0, 64'd0, 2'b11);
        req("half_misal", 64'h8000_0001, 2'b01, 1'b0, 0, '0, 1'b0, 1'b0, 64'd0, 2'b10);
        req("top_line", 64'h87FF_FFF8, 2'b11, 1'b1, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0,
            64'h0123_4567_89AB_CDEF, 2'b00);

        req("byte7", 64'h8000_0007, 2'b00, 1'b1, 1, 64'hAB00_0000_0000_0000, 1'b0, 1'b0,
            64'h0000_0000_0000_00AB, 2'b00);
        req("half6", 64'h8000_0006, 2'b01, !LB, 0, 64'hAB00_0000_0000_0000, 1'b0, 1'b0,
            64'h0000_0000_0000_AB00, 2'b00);
        req("dbl0", 64'h8000_0000, 2'b11, !LB, 0, 64'hAB00_0000_0000_0000, 1'b0, 1'b0,
            64'hAB00_0000_0000_0000, 2'b00);
        req("byte6", 64'h8000_0006, 2'b00, !LB, 0, 64'hAB00_0000_0000_0000, 1'b0, 1'b0,
            64'h0000_0000_0000_0000, 2'b00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
